branch_predictor: RTL and testbench

- Parametrised direct-mapped branch target buffer (BTB) with saturating-counter direction prediction, sitting beside the fetch stage of the 5-stage RV32 pipeline.
- Fetch looks up PCF combinationally and gets a predicted-taken flag and target in the same cycle.
- Execute returns resolved outcomes for branches and jumps so the predictor can update.
- Supports a bimodal mode and a gshare mode (global history XOR index), selected by parameter.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/bp_sat_counter.sv | 29 ++
 rtl/branch_predictor.sv | 105 ++++++++++
 tb/tb_branch_predictor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: counter saturation limits and
// PC-to-index/tag extraction, written on a wide word so any table geometry fits.
package bp_pkg;
    localparam int BP_W = 64;
    typedef logic [BP_W-1:0] bp_word_t;

    function automatic bp_word_t bp_mask(input int bits);
        return (bp_word_t'(1) << bits) - bp_word_t'(1);
    endfunction

    function automatic bp_word_t bp_ctr_max(input int bits);
        return bp_mask(bits);
    endfunction

    function automatic bp_word_t bp_ctr_weak_taken(input int bits);
        return bp_word_t'(1) << (bits - 1);
    endfunction

    function automatic bp_word_t ctr_sat_inc(input bp_word_t c, input int bits);
        return (c >= bp_ctr_max(bits)) ? c : c + bp_word_t'(1);
    endfunction

    function automatic bp_word_t ctr_sat_dec(input bp_word_t c);
        return (c == '0) ? c : c - bp_word_t'(1);
    endfunction

    // Word-aligned PC bits, optionally hashed with global history
    function automatic bp_word_t bp_index(input bp_word_t pc, input bp_word_t ghr, input int idx_bits);
        return ((pc >> 2) ^ ghr) & bp_mask(idx_bits);
    endfunction

    function automatic bp_word_t bp_tag(input bp_word_t pc, input int idx_bits);
        return pc >> (idx_bits + 2);
    endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down direction counter with a parallel load; load wins over count.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [CTR_BITS-1:0] i_load_val,
    input  logic                i_inc,
    input  logic                i_dec,
    output logic [CTR_BITS-1:0] o_ctr
);
    logic [CTR_BITS-1:0] r_ctr;

    always_ff @(posedge clk) begin
        if (rst)
            r_ctr <= '0;
        else if (i_load)
            r_ctr <= i_load_val;
        else if (i_inc)
            r_ctr <= CTR_BITS'(ctr_sat_inc(bp_word_t'(r_ctr), CTR_BITS));
        else if (i_dec)
            r_ctr <= CTR_BITS'(ctr_sat_dec(bp_word_t'(r_ctr)));
    end

    assign o_ctr = r_ctr;
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters; bimodal when
// GHR_BITS=0, gshare otherwise. Lookup is combinational, update lands at the edge.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       pc_f_i,
    output logic                        pred_taken_o,
    output logic [DATA_WIDTH-1:0]       pred_target_o,
    output logic [$clog2(ENTRIES)-1:0]  pred_idx_o,
    input  logic                        update_valid_i,
    input  logic                        update_is_jump_i,
    input  logic [$clog2(ENTRIES)-1:0]  update_idx_i,
    input  logic [DATA_WIDTH-1:0]       update_pc_i,
    input  logic                        update_taken_i,
    input  logic [DATA_WIDTH-1:0]       update_target_i,
    input  logic                        flush_i
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_W    = DATA_WIDTH - IDX_BITS - 2;
    localparam int GHR_W    = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam logic [CTR_BITS-1:0] CTR_MAX        = CTR_BITS'(bp_ctr_max(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = CTR_BITS'(bp_ctr_weak_taken(CTR_BITS));

    logic [ENTRIES-1:0]    r_valid;
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [DATA_WIDTH-1:0] r_target [ENTRIES];
    logic [GHR_W-1:0]      r_ghr;

    bp_word_t              w_ghr_ext;
    logic [IDX_BITS-1:0]   w_idx;
    logic [TAG_W-1:0]      w_tag_f, w_tag_u;
    logic                  w_hit_f, w_hit_u;
    logic                  w_upd, w_write, w_ld, w_inc, w_dec;
    logic [CTR_BITS-1:0]   w_ld_val;
    logic [CTR_BITS-1:0]   w_ctr [ENTRIES];

    always_comb begin
        w_ghr_ext = '0;
        if (GHR_BITS > 0)
            w_ghr_ext[GHR_W-1:0] = r_ghr;
    end

    assign w_idx   = IDX_BITS'(bp_index(bp_word_t'(pc_f_i), w_ghr_ext, IDX_BITS));
    assign w_tag_f = TAG_W'(bp_tag(bp_word_t'(pc_f_i), IDX_BITS));
    assign w_tag_u = TAG_W'(bp_tag(bp_word_t'(update_pc_i), IDX_BITS));
    assign w_hit_f = r_valid[w_idx] && (r_tag[w_idx] == w_tag_f);
    assign w_hit_u = r_valid[update_idx_i] && (r_tag[update_idx_i] == w_tag_u);

    assign pred_taken_o  = w_hit_f && w_ctr[w_idx][CTR_BITS-1];
    assign pred_target_o = pred_taken_o ? r_target[w_idx] : '0;
    assign pred_idx_o    = w_idx;

    // Jumps always (re)allocate at max strength; branches allocate only when taken
    assign w_upd    = update_valid_i && !flush_i;
    assign w_write  = w_upd && (update_is_jump_i || update_taken_i);
    assign w_ld     = w_upd && (update_is_jump_i || (!w_hit_u && update_taken_i));
    assign w_ld_val = update_is_jump_i ? CTR_MAX : CTR_WEAK_TAKEN;
    assign w_inc    = w_upd && w_hit_u && !update_is_jump_i && update_taken_i;
    assign w_dec    = w_upd && w_hit_u && !update_is_jump_i && !update_taken_i;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic w_sel;
        assign w_sel = (update_idx_i == IDX_BITS'(g));
        bp_sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_ld && w_sel),
            .i_load_val (w_ld_val),
            .i_inc      (w_inc && w_sel),
            .i_dec      (w_dec && w_sel),
            .o_ctr      (w_ctr[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_ghr   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else begin
            if (flush_i) begin
                r_valid <= '0;
            end else if (w_write) begin
                r_valid[update_idx_i]  <= 1'b1;
                r_tag[update_idx_i]    <= w_tag_u;
                r_target[update_idx_i] <= update_target_i;
            end
            // History tracks resolved conditional branches only
            if (flush_i)
                r_ghr <= '0;
            else if (GHR_BITS > 0 && update_valid_i && !update_is_jump_i)
                r_ghr <= GHR_W'({r_ghr, update_taken_i});
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: bimodal predictor driven from a vector table plus hand
// sequences for no-bypass, reset and a gshare instance.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] pc = '0, upd_pc = '0, upd_tgt = '0, p_tgt;
    logic        upd_v = 0, upd_j = 0, upd_t = 0, flush = 0, p_t;
    logic [3:0]  upd_idx = '0, p_idx;

    logic [31:0] g_pc = '0, g_upd_pc = '0, g_upd_tgt = '0, g_p_tgt;
    logic        g_upd_v = 0, g_upd_j = 0, g_upd_t = 0, g_flush = 0, g_p_t;
    logic [3:0]  g_upd_idx = '0, g_p_idx;

    branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .CTR_BITS(2), .GHR_BITS(0)) dut (
        .clk(clk), .rst(rst), .pc_f_i(pc), .pred_taken_o(p_t), .pred_target_o(p_tgt),
        .pred_idx_o(p_idx), .update_valid_i(upd_v), .update_is_jump_i(upd_j),
        .update_idx_i(upd_idx), .update_pc_i(upd_pc), .update_taken_i(upd_t),
        .update_target_i(upd_tgt), .flush_i(flush)
    );

    branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .CTR_BITS(2), .GHR_BITS(4)) dut_g (
        .clk(clk), .rst(rst), .pc_f_i(g_pc), .pred_taken_o(g_p_t), .pred_target_o(g_p_tgt),
        .pred_idx_o(g_p_idx), .update_valid_i(g_upd_v), .update_is_jump_i(g_upd_j),
        .update_idx_i(g_upd_idx), .update_pc_i(g_upd_pc), .update_taken_i(g_upd_t),
        .update_target_i(g_upd_tgt), .flush_i(g_flush)
    );

    typedef struct {
        logic        uv, uj;
        logic [3:0]  ui;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        fl;
        logic [31:0] lpc;
        logic        et;
        logic [31:0] etgt;
        logic [3:0]  eidx;
        string       nm;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(input string nm, input logic uv, input logic uj, input logic [3:0] ui,
                                input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                                input logic fl, input logic [31:0] lpc, input logic et,
                                input logic [31:0] etgt, input logic [3:0] eidx);
        vec_t v;
        v.nm = nm; v.uv = uv; v.uj = uj; v.ui = ui; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.fl = fl; v.lpc = lpc; v.et = et; v.etgt = etgt; v.eidx = eidx;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_pred(input string nm, input logic et, input logic [31:0] etgt, input logic [3:0] eidx);
        chk({nm, ".taken"}, {31'd0, p_t}, {31'd0, et});
        chk({nm, ".target"}, p_tgt, etgt);
        chk({nm, ".idx"}, {28'd0, p_idx}, {28'd0, eidx});
    endtask

    task automatic chk_g(input string nm, input logic et, input logic [31:0] etgt, input logic [3:0] eidx);
        chk({nm, ".taken"}, {31'd0, g_p_t}, {31'd0, et});
        chk({nm, ".target"}, g_p_tgt, etgt);
        chk({nm, ".idx"}, {28'd0, g_p_idx}, {28'd0, eidx});
    endtask

    task automatic clr_upd();
        upd_v = 0; upd_j = 0; upd_t = 0; upd_idx = '0; upd_pc = '0; upd_tgt = '0; flush = 0;
    endtask

    task automatic g_upd(input logic j, input logic [31:0] upc, input logic [3:0] ui,
                         input logic t, input logic [31:0] tgt);
        g_upd_v = 1; g_upd_j = j; g_upd_pc = upc; g_upd_idx = ui; g_upd_t = t; g_upd_tgt = tgt;
        @(posedge clk); #1;
        g_upd_v = 0; g_upd_j = 0; g_upd_t = 0;
    endtask

    initial begin
        // idx(0x40)=0 tag 1; idx(0x80)=0 tag 2; idx(0x24)=9 tag 0; idx(0x3C)=15
        vecs.push_back(mk("nt_to1",   1,0,0,32'h40,0,32'h0,  0,32'h40,0,32'h0,  0));
        vecs.push_back(mk("nt_to0",   1,0,0,32'h40,0,32'h0,  0,32'h40,0,32'h0,  0));
        vecs.push_back(mk("nt_sat0",  1,0,0,32'h40,0,32'h0,  0,32'h40,0,32'h0,  0));
        vecs.push_back(mk("t_to1",    1,0,0,32'h40,1,32'h10, 0,32'h40,0,32'h0,  0));
        vecs.push_back(mk("t_to2",    1,0,0,32'h40,1,32'h10, 0,32'h40,1,32'h10, 0));
        vecs.push_back(mk("t_to3",    1,0,0,32'h40,1,32'h14, 0,32'h40,1,32'h14, 0));
        vecs.push_back(mk("t_sat3",   1,0,0,32'h40,1,32'h14, 0,32'h40,1,32'h14, 0));
        vecs.push_back(mk("nt_3to2",  1,0,0,32'h40,0,32'h0,  0,32'h40,1,32'h14, 0));
        vecs.push_back(mk("alias",    0,0,0,32'h0, 0,32'h0,  0,32'h80,0,32'h0,  0));
        vecs.push_back(mk("miss_nt",  1,0,0,32'h80,0,32'h0,  0,32'h80,0,32'h0,  0));
        vecs.push_back(mk("replace",  1,0,0,32'h80,1,32'h200,0,32'h80,1,32'h200,0));
        vecs.push_back(mk("evicted",  0,0,0,32'h0, 0,32'h0,  0,32'h40,0,32'h0,  0));
        vecs.push_back(mk("jal",      1,1,9,32'h24,1,32'h100,0,32'h24,1,32'h100,9));
        vecs.push_back(mk("jal_max",  1,0,9,32'h24,0,32'h0,  0,32'h24,1,32'h100,9));
        vecs.push_back(mk("idx15",    0,0,0,32'h0, 0,32'h0,  0,32'h3C,0,32'h0,  15));
        vecs.push_back(mk("flush",    1,0,0,32'h40,1,32'h300,1,32'h24,0,32'h0,  9));
        vecs.push_back(mk("fl_80",    0,0,0,32'h0, 0,32'h0,  0,32'h80,0,32'h0,  0));
        vecs.push_back(mk("fl_drop",  0,0,0,32'h0, 0,32'h0,  0,32'h40,0,32'h0,  0));
        vecs.push_back(mk("realloc",  1,0,0,32'h40,1,32'h44, 0,32'h40,1,32'h44, 0));
        vecs.push_back(mk("weak_nt",  1,0,0,32'h40,0,32'h0,  0,32'h40,0,32'h0,  0));

        // Reset, with an update held during reset that must be ignored
        upd_v = 1; upd_pc = 32'h40; upd_idx = 0; upd_t = 1; upd_tgt = 32'h10; pc = 32'h40;
        repeat (2) @(posedge clk);
        #1 rst = 0; clr_upd();
        #1 chk_pred("reset", 0, 32'h0, 0);
        chk_g("g_reset", 0, 32'h0, 0);

        // No bypass: same-cycle lookup sees old contents
        upd_v = 1; upd_pc = 32'h40; upd_idx = 0; upd_t = 1; upd_tgt = 32'h10; pc = 32'h40;
        #1 chk_pred("same_cycle", 0, 32'h0, 0);
        @(posedge clk); #1 clr_upd();
        #1 chk_pred("alloc", 1, 32'h10, 0);

        foreach (vecs[k]) begin
            upd_v = vecs[k].uv; upd_j = vecs[k].uj; upd_idx = vecs[k].ui; upd_pc = vecs[k].upc;
            upd_t = vecs[k].ut; upd_tgt = vecs[k].utgt; flush = vecs[k].fl; pc = vecs[k].lpc;
            @(posedge clk); #1 clr_upd();
            #1 chk_pred(vecs[k].nm, vecs[k].et, vecs[k].etgt, vecs[k].eidx);
        end

        // Mid-stream reset discards history and ignores the concurrent update
        upd_v = 1; upd_j = 1; upd_idx = 9; upd_pc = 32'h24; upd_t = 1; upd_tgt = 32'h100; pc = 32'h24;
        @(posedge clk); #1 clr_upd();
        #1 chk_pred("pre_rst", 1, 32'h100, 9);
        rst = 1; upd_v = 1; upd_idx = 0; upd_pc = 32'h80; upd_t = 1; upd_tgt = 32'h600;
        @(posedge clk); #1 rst = 0; clr_upd();
        #1 chk_pred("rst_24", 0, 32'h0, 9);
        pc = 32'h80;
        #1 chk_pred("rst_80", 0, 32'h0, 0);

        // Gshare: T,T,NT -> ghr=0110
        g_upd(0, 32'h0, 0, 1, 32'h900);
        g_upd(0, 32'h0, 0, 1, 32'h900);
        g_upd(0, 32'h0, 0, 0, 32'h0);
        g_pc = 32'h40;
        #1 chk_g("g_idx6", 0, 32'h0, 6);
        g_upd(0, 32'h40, 6, 1, 32'h500);          // ghr=1101
        g_pc = 32'h6C;                            // 11 ^ 13 = 6
        #1 chk_g("g_alloc6", 1, 32'h500, 6);
        g_upd(0, 32'h40, 6, 0, 32'h0);            // hit: ctr 2->1, ghr=1010
        g_pc = 32'h70;                            // 12 ^ 10 = 6
        #1 chk_g("g_hit_dec", 0, 32'h0, 6);
        g_upd(1, 32'h0C, 3, 1, 32'h700);          // jump leaves ghr alone
        #1 chk_g("g_jump_ghr", 0, 32'h0, 6);
        g_flush = 1;
        @(posedge clk); #1 g_flush = 0;
        g_pc = 32'h40;
        #1 chk_g("g_flush", 0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
